// File: rtl/huffman_param.sv
// huffman_param: counts symbol occurrences over a frame, then builds a Huffman
// code per symbol by repeatedly merging the two lightest active nodes.
module huffman_param #(
    parameter int unsigned NSYM = 6,
    parameter int unsigned CW   = 8,
    parameter int unsigned LW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gray_valid,
    input  logic [7:0]           gray_data,
    output logic                 cnt_valid,
    output logic [NSYM*CW-1:0]   cnt_flat,
    output logic                 code_valid,
    output logic [NSYM*LW-1:0]   hc_flat,
    output logic [NSYM*LW-1:0]   m_flat,
    output logic                 busy
);

    // Node weights hold the sum of all counts, so they never wrap.
    localparam int unsigned WW   = CW + $clog2(NSYM);
    localparam int unsigned IW   = $clog2(NSYM);
    localparam int unsigned LENW = $clog2(LW + 1);

    // Reject parameter sets that cannot hold the longest possible code.
    generate
        if ((NSYM < 2) || (NSYM > 16) || (NSYM - 1 > LW)) begin : g_bad_param
            $error("huffman_param: illegal NSYM/LW combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        CNT_OUT,
        SCAN,
        MERGE,
        CODE_OUT
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt     [NSYM];
    logic [NSYM-1:0]     act;
    logic [WW-1:0]       wt      [NSYM];
    logic [NSYM-1:0]     members [NSYM];
    logic [LW-1:0]       hc      [NSYM];
    logic [LW-1:0]       mk      [NSYM];
    logic [LENW-1:0]     len     [NSYM];
    logic [IW-1:0]       scan_idx;
    logic [IW-1:0]       merge_cnt;
    logic [IW-1:0]       min1;
    logic [IW-1:0]       min2;
    logic                min1_ok;
    logic                min2_ok;

    logic [IW-1:0]       merge_lo_c;
    logic [IW-1:0]       merge_hi_c;
    logic [WW-1:0]       merge_w_c;
    logic [NSYM-1:0]     merge_set_c;

    // Merged node lands in the lower slot index of the selected pair.
    always_comb begin
        merge_lo_c  = (min1 < min2) ? min1 : min2;
        merge_hi_c  = (min1 < min2) ? min2 : min1;
        merge_w_c   = wt[min1] + wt[min2];
        merge_set_c = members[min1] | members[min2];
    end

    // Flatten per-symbol registers onto the output buses, symbol 1 at the LSBs.
    always_comb begin
        cnt_flat = '0;
        hc_flat  = '0;
        m_flat   = '0;
        for (int k = 0; k < NSYM; k++) begin
            cnt_flat[k*CW +: CW] = cnt[k];
            hc_flat[k*LW +: LW]  = hc[k];
            m_flat[k*LW +: LW]   = mk[k];
        end
    end

    // Control FSM with counting, scan and merge datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt_valid  <= 1'b0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            scan_idx   <= '0;
            merge_cnt  <= '0;
            min1       <= '0;
            min2       <= '0;
            min1_ok    <= 1'b0;
            min2_ok    <= 1'b0;
            act        <= '0;
            for (int k = 0; k < NSYM; k++) begin
                cnt[k]     <= '0;
                wt[k]      <= '0;
                members[k] <= '0;
                hc[k]      <= '0;
                mk[k]      <= '0;
                len[k]     <= '0;
            end
        end else begin
            cnt_valid  <= 1'b0;
            code_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gray_valid) begin
                        for (int k = 0; k < NSYM; k++) begin
                            cnt[k]     <= (gray_data == 8'(k + 1)) ? CW'(1) : '0;
                            wt[k]      <= '0;
                            members[k] <= '0;
                            hc[k]      <= '0;
                            mk[k]      <= '0;
                            len[k]     <= '0;
                        end
                        act   <= '0;
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (gray_valid) begin
                        for (int k = 0; k < NSYM; k++) begin
                            if ((gray_data == 8'(k + 1)) && (cnt[k] != {CW{1'b1}})) begin
                                cnt[k] <= cnt[k] + CW'(1);
                            end
                        end
                    end else begin
                        state     <= CNT_OUT;
                        cnt_valid <= 1'b1;
                    end
                end
                CNT_OUT: begin
                    for (int k = 0; k < NSYM; k++) begin
                        wt[k]      <= WW'(cnt[k]);
                        members[k] <= NSYM'(1) << k;
                    end
                    act       <= '1;
                    scan_idx  <= '0;
                    merge_cnt <= '0;
                    min1_ok   <= 1'b0;
                    min2_ok   <= 1'b0;
                    state     <= SCAN;
                end
                SCAN: begin
                    // Strict less-than in ascending index order keeps the lower index on ties.
                    if (act[scan_idx]) begin
                        if (!min1_ok || (wt[scan_idx] < wt[min1])) begin
                            min2    <= min1;
                            min2_ok <= min1_ok;
                            min1    <= scan_idx;
                            min1_ok <= 1'b1;
                        end else if (!min2_ok || (wt[scan_idx] < wt[min2])) begin
                            min2    <= scan_idx;
                            min2_ok <= 1'b1;
                        end
                    end
                    if (scan_idx == IW'(NSYM - 1)) begin
                        scan_idx <= '0;
                        state    <= MERGE;
                    end else begin
                        scan_idx <= scan_idx + IW'(1);
                    end
                end
                MERGE: begin
                    for (int k = 0; k < NSYM; k++) begin
                        if (members[min1][k]) begin
                            hc[k]  <= hc[k] | (LW'(1) << len[k]);
                            mk[k]  <= mk[k] | (LW'(1) << len[k]);
                            len[k] <= len[k] + LENW'(1);
                        end else if (members[min2][k]) begin
                            mk[k]  <= mk[k] | (LW'(1) << len[k]);
                            len[k] <= len[k] + LENW'(1);
                        end
                    end
                    wt[merge_lo_c]      <= merge_w_c;
                    members[merge_lo_c] <= merge_set_c;
                    act[merge_hi_c]     <= 1'b0;
                    min1_ok             <= 1'b0;
                    min2_ok             <= 1'b0;
                    merge_cnt           <= merge_cnt + IW'(1);
                    if (merge_cnt == IW'(NSYM - 2)) begin
                        state      <= CODE_OUT;
                        code_valid <= 1'b1;
                    end else begin
                        state <= SCAN;
                    end
                end
                CODE_OUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/huffman_param.md
HUFFMAN_PARAM -- requirements
Module: huffman_param

Interface
REQ-001 Parameter NSYM, default 6: number of symbols, values 1..NSYM; legal range 2..16.
REQ-002 Parameter CW, default 8: per-symbol count width.
REQ-003 Parameter LW, default 8: code/mask width per symbol; elaboration fails if NSYM-1 > LW.
REQ-004 clk  in  1  clock; all state changes on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 gray_valid  in  1  input sample qualifier; frame ends at first low cycle.
REQ-007 gray_data  in  8  symbol value; only 1..NSYM are counted.
REQ-008 cnt_valid  out  1  one-cycle pulse; cnt_flat valid.
REQ-009 cnt_flat  out  NSYM*CW  count of symbol k in slice [(k-1)*CW +: CW].
REQ-010 code_valid  out  1  one-cycle pulse; hc_flat/m_flat valid.
REQ-011 hc_flat  out  NSYM*LW  Huffman code of symbol k in slice [(k-1)*LW +: LW].
REQ-012 m_flat  out  NSYM*LW  code mask of symbol k; ones in bits [len-1:0].
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, COUNT, CNT_OUT, SCAN, MERGE, CODE_OUT.
REQ-015 IDLE->COUNT on gray_valid=1.
- Same cycle clears all counts, codes and masks, then counts that sample.
REQ-016 COUNT: each gray_valid=1 cycle increments the matching count.
- First gray_valid=0 cycle -> CNT_OUT.
REQ-017 Counts saturate at 2^CW-1.
REQ-018 Out-of-range gray_data (0, >NSYM) is ignored without error.
REQ-019 gray_valid is ignored in CNT_OUT, SCAN, MERGE and CODE_OUT.
REQ-020 CNT_OUT, one cycle: cnt_valid=1.
- Loads NSYM node slots with {active=1, weight=count, member set={k}}.
- Next state SCAN.
REQ-021 Node weights are CW+clog2(NSYM) bits wide; merge sums never wrap.
REQ-022 SCAN: NSYM cycles, one slot per cycle in index order 1..NSYM.
- Tracks min1 and min2 over active slots only.
REQ-023 Ordering key is (weight, slot index): lower weight first; equal weight -> lower slot index first.
REQ-024 MERGE, one cycle, for the two selected slots min1 and min2:
- Every symbol in min1 gets bit 1 and every symbol in min2 gets bit 0, written at that symbol's current length position (LSB first = leaf level).
- Each of those symbols increments its length and sets the matching mask bit.
- Merged node (weight sum, member union) goes into the lower slot index of the pair; the other slot is deactivated.
REQ-025 MERGE -> SCAN until NSYM-1 merges are done, then -> CODE_OUT.
REQ-026 CODE_OUT, one cycle: code_valid=1, then -> IDLE.
REQ-027 Latency: code_valid is asserted 1+(NSYM-1)*(NSYM+1) cycles after cnt_valid (36 for NSYM=6).
REQ-028 cnt_flat, hc_flat and m_flat hold their values until the next frame start (REQ-015) or reset.
REQ-029 Zero-count symbols take part in the tree like any other node.

Reset
REQ-030 reset=1 at any clock returns the FSM to IDLE, including mid-frame.
- All counts, slots, hc_flat, m_flat and length counters clear to 0.
- cnt_valid=0, code_valid=0, busy=0.
REQ-031 reset has priority over every other input.

Verification
REQ-032 NSYM=6: counts 1:10,2:5,3:4,4:3,5:2,6:1 -> cnt_valid with those counts.
- HC = 01,00,01,03,04,05; M = 01,07,07,07,0F,0F (hex).
- code_valid 36 cycles after cnt_valid.
REQ-033 All six counts = 4 -> HC = 03,02,01,00,03,02; M = 07,07,07,07,03,03 (tie rule REQ-023).
REQ-034 300 samples of symbol 1 plus one each of 2..6 -> CNT1=255 (saturated).
- Merge weights stay correct (no wrap).
REQ-035 Frame mixing 0, 7 and 255 with valid symbols -> out-of-range values are not counted.
- A second back-to-back frame starts with all counts and codes cleared.
REQ-036 reset asserted during the 3rd SCAN cycle of round 2 -> next cycle busy=0 and all outputs 0.
- A following frame produces the REQ-032 result unchanged.
